tdma_scheduler: RTL and testbench
=================================

# tdma_scheduler

Parametrised time-division arbiter for the MemorEDF queue front-end. It grants each of `NUMBER_OF_QUEUES` queues a programmable slot of `delta[i]` cycles per frame. Slot lengths are double-buffered and take effect only at frame boundaries, and zero-length slots are skipped. An optional work-conserving mode hands an idle slot to the next non-empty queue. It sits between the per-queue request FIFOs and the memory-port mux, and drives the mux select.

## Interface
- `NUMBER_OF_QUEUES`, 4, number of queues/slots (≥2)
- `REGISTER_SIZE`, 32, width of each slot length and of the slot counter
- `WORK_CONSERVING`, 0, 0 = strict TDMA; 1 = reassign a slot whose owner is empty
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `delta`  in  `NUMBER_OF_QUEUES`×`REGISTER_SIZE`  shadow slot lengths in cycles; 0 = slot absent
- `update`  in  1  single-cycle request to load `delta` at the next frame boundary
- `empty`  in  `NUMBER_OF_QUEUES`  per-queue FIFO empty flags
- `valid`  out  1  `selection` names a non-empty queue that may issue
- `selection`  out  `$clog2(NUMBER_OF_QUEUES)`  granted queue index
- `frame_start`  out  1  one-cycle pulse on the first output cycle of each frame
- `active_slot`  out  `$clog2(NUMBER_OF_QUEUES)`  TDMA slot owner, which may differ from `selection` in work-conserving mode

## Operation
- State registers: `active[i]` (in-use slot lengths), `slot` (current slot index), `cnt` (cycles elapsed in slot), `pending` (load request), `idle`.
- Reset sets all outputs to 0, `active` to all zero, `slot`/`cnt` to 0, `idle` to 1, and `pending` to 1. The post-reset load is therefore automatic.
- Frame boundary:
  - It occurs in the last cycle of the last non-zero slot, i.e. `cnt == active[slot]-1` and no non-zero slot has a higher index.
  - While `idle`, every cycle is a frame boundary.
- Load at a boundary when `pending` is set:
  - `active <= delta` (sampled that cycle); clear `pending`.
  - `slot <=` lowest index with `delta[i] != 0`; `cnt <= 0`.
  - `idle <= (all delta == 0)`.
- Without a load, a boundary wraps to the lowest non-zero index of `active`.
- Within a frame:
  - `cnt` increments each cycle.
  - When `cnt == active[slot]-1`, `slot <=` next higher index with non-zero `active` and `cnt <= 0`.
  - Zero-length slots consume no cycles.
- `update` sets `pending`.
  - If `update` arrives in the same cycle as a load, the load consumes it and `pending` ends cleared.
  - Repeated `update` pulses before a boundary collapse into one load.
- Grant, strict mode: `selection = slot`, `valid = ~empty[slot]`.
- Grant, work-conserving mode:
  - If `empty[slot]`, `selection` is the first non-empty queue searching `slot+1, slot+2, …` modulo N, and `valid = 1`.
  - If all queues are empty, `selection = slot`, `valid = 0`.
  - Slot timing is never altered by reassignment.
- `idle`: `valid = 0`, `selection = 0`, `active_slot = 0`, `frame_start = 0`.
- Width rules:
  - `cnt` is `REGISTER_SIZE` bits.
  - `delta[i]` up to 2^`REGISTER_SIZE`−1 is legal.
  - No frame-sum register exists, so frame length cannot overflow.

## Timing
- All outputs are registered. Output cycle t+1 reflects `slot`/`cnt` state and `empty` as sampled in cycle t (1-cycle latency).
- After reset deassertion:
  - The first edge performs the load.
  - The second edge presents the first slot on the outputs, with `frame_start = 1`.
- A slot of length d holds `active_slot` for exactly d consecutive output cycles.
- `frame_start` is high on the output cycle showing the first cycle of the first non-zero slot after a boundary, including the first frame after a load.
- A new `delta` value is visible only in the frame after the boundary at which it is loaded. Changing `delta` mid-frame without `update` has no effect.
- Reset asserted mid-frame:
  - Outputs go to 0 immediately (asynchronously).
  - The frame restarts from the lowest non-zero slot using `delta` as sampled at the first edge after release.

## Test plan
- Reset release; `delta = {2,1,0,3}` (index 0 first), all queues non-empty → `active_slot` sequence 0,0,1,3,3,3 repeating; `frame_start` on each first 0; `valid = 1` throughout.
- Same `delta`, `empty[1] = 1`:
  - Strict mode → `valid = 0` during slot 1.
  - `WORK_CONSERVING = 1` → `selection = 2` (the next non-empty queue), `valid = 1`, `active_slot = 1`.
- Mid-frame: `delta <= {1,1,1,1}` plus an `update` pulse → current frame completes unchanged, then the pattern 0,1,2,3 starts with `frame_start`.
- All `delta = 0` after reset → `valid = 0` indefinitely. Then `delta = {0,0,5,0}` with `update` → `active_slot = 2` continuously, `frame_start` every 5 cycles.
- Reset asserted during slot 3 → outputs read 0 before the next edge. After release, the sequence restarts at slot 0 with `frame_start`.
- `delta[0] = 2^REGISTER_SIZE−1` with a reduced `REGISTER_SIZE = 4` build → slot 0 lasts exactly 15 cycles with no counter wrap error.

Source files
------------

// File: rtl/tdma_scheduler.sv
// Time-division arbiter: grants each queue a programmable slot of delta[i] cycles per frame.
// Slot lengths are double-buffered and switch only at frame boundaries; an optional mode lends idle slots.
module tdma_scheduler #(
    parameter int  NUMBER_OF_QUEUES = 4,
    parameter int  REGISTER_SIZE    = 32,
    parameter bit  WORK_CONSERVING  = 1'b0,
    localparam int SW               = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   delta,
    input  logic                                             update,
    input  logic [NUMBER_OF_QUEUES-1:0]                      empty,
    output logic                                             valid,
    output logic [SW-1:0]                                    selection,
    output logic                                             frame_start,
    output logic [SW-1:0]                                    active_slot
);
    localparam int N = NUMBER_OF_QUEUES;
    localparam int W = REGISTER_SIZE;

    logic [N-1:0][W-1:0] active_q;
    logic [SW-1:0]       slot_q;
    logic [W-1:0]        cnt_q;
    logic                pending_q;
    logic                idle_q;
    logic                valid_q;
    logic [SW-1:0]       sel_q;
    logic                fs_q;
    logic [SW-1:0]       as_q;

    logic [SW-1:0]       first_act_s;
    logic [SW-1:0]       first_dly_s;
    logic [SW-1:0]       next_s;
    logic                has_next_s;
    logic                slot_end_s;
    logic                boundary_s;
    logic                load_s;
    logic [SW-1:0]       sel_s;
    logic                valid_s;
    logic                fs_s;

    assign valid       = valid_q;
    assign selection   = sel_q;
    assign frame_start = fs_q;
    assign active_slot = as_q;

    // Slot search, frame-boundary detection and grant selection
    always_comb begin
        first_act_s = '0;
        first_dly_s = '0;
        next_s      = '0;
        has_next_s  = 1'b0;
        // Descending scan: the last hit is the lowest qualifying index
        for (int k = N - 1; k >= 0; k--) begin
            first_act_s = (active_q[k] != '0) ? SW'(k) : first_act_s;
            first_dly_s = (delta[k] != '0) ? SW'(k) : first_dly_s;
            next_s      = ((k > int'(slot_q)) && (active_q[k] != '0)) ? SW'(k) : next_s;
            has_next_s  = has_next_s | ((k > int'(slot_q)) && (active_q[k] != '0));
        end

        slot_end_s = (cnt_q == (active_q[slot_q] - W'(1)));
        boundary_s = idle_q | (slot_end_s & ~has_next_s);
        load_s     = boundary_s & pending_q;

        sel_s   = slot_q;
        valid_s = ~empty[slot_q];
        if (WORK_CONSERVING && empty[slot_q]) begin
            // Nearest non-empty queue after the owner, wrapping modulo N
            for (int k = N - 1; k >= 1; k--) begin
                sel_s   = (!empty[(int'(slot_q) + k) % N]) ? SW'((int'(slot_q) + k) % N) : sel_s;
                valid_s = valid_s | !empty[(int'(slot_q) + k) % N];
            end
        end else begin
            sel_s = slot_q;
        end

        fs_s = ~idle_q & (cnt_q == '0) & (slot_q == first_act_s);
    end

    // Schedule state and registered grant outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_q  <= '0;
            slot_q    <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b1;
            idle_q    <= 1'b1;
            valid_q   <= 1'b0;
            sel_q     <= '0;
            fs_q      <= 1'b0;
            as_q      <= '0;
        end else begin
            pending_q <= ~load_s & (pending_q | update);

            if (load_s) begin
                active_q <= delta;
                slot_q   <= first_dly_s;
                cnt_q    <= '0;
                idle_q   <= (delta == '0);
            end else if (!idle_q) begin
                if (slot_end_s) begin
                    slot_q <= has_next_s ? next_s : first_act_s;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + W'(1);
                end
            end

            if (idle_q) begin
                valid_q <= 1'b0;
                sel_q   <= '0;
                fs_q    <= 1'b0;
                as_q    <= '0;
            end else begin
                valid_q <= valid_s;
                sel_q   <= sel_s;
                fs_q    <= fs_s;
                as_q    <= slot_q;
            end
        end
    end

endmodule

// File: tb/tb_tdma_scheduler.sv
// Directed bench for tdma_scheduler: strict, work-conserving and 4-bit builds checked cycle by cycle
// against hand-derived slot sequences.
module tb_tdma_scheduler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset;
    logic             rst4;
    logic             update;
    logic [3:0]       empty;
    logic [3:0][31:0] delta;
    logic [3:0][3:0]  delta4;

    logic       v_o, fs_o, wv_o, wfs_o, v4_o, fs4_o;
    logic [1:0] sel_o, as_o, wsel_o, was_o, sel4_o, as4_o;

    int total = 0;
    int bad   = 0;

    tdma_scheduler #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32), .WORK_CONSERVING(1'b0)) dut (
        .clock(clock), .reset(reset), .delta(delta), .update(update), .empty(empty),
        .valid(v_o), .selection(sel_o), .frame_start(fs_o), .active_slot(as_o));

    tdma_scheduler #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32), .WORK_CONSERVING(1'b1)) dut_wc (
        .clock(clock), .reset(reset), .delta(delta), .update(update), .empty(empty),
        .valid(wv_o), .selection(wsel_o), .frame_start(wfs_o), .active_slot(was_o));

    tdma_scheduler #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(4), .WORK_CONSERVING(1'b0)) dut_w4 (
        .clock(clock), .reset(rst4), .delta(delta4), .update(update), .empty(empty),
        .valid(v4_o), .selection(sel4_o), .frame_start(fs4_o), .active_slot(as4_o));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input int a, input int f, input int v, input int s);
        check({tag, ".as"},  32'(as_o),  32'(a));
        check({tag, ".fs"},  32'(fs_o),  32'(f));
        check({tag, ".v"},   32'(v_o),   32'(v));
        check({tag, ".sel"}, 32'(sel_o), 32'(s));
    endtask

    task automatic chk_wc(input string tag, input int a, input int f, input int v, input int s);
        check({tag, ".wc.as"},  32'(was_o),  32'(a));
        check({tag, ".wc.fs"},  32'(wfs_o),  32'(f));
        check({tag, ".wc.v"},   32'(wv_o),   32'(v));
        check({tag, ".wc.sel"}, 32'(wsel_o), 32'(s));
    endtask

    task automatic chk_w4(input string tag, input int a, input int f, input int v);
        check({tag, ".w4.as"}, 32'(as4_o), 32'(a));
        check({tag, ".w4.fs"}, 32'(fs4_o), 32'(f));
        check({tag, ".w4.v"},  32'(v4_o),  32'(v));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_delta(input int d0, input int d1, input int d2, input int d3);
        delta[0] = 32'(d0);
        delta[1] = 32'(d1);
        delta[2] = 32'(d2);
        delta[3] = 32'(d3);
    endtask

    int f1[6] = '{0, 0, 1, 3, 3, 3};

    initial begin
        reset  = 1'b1;
        rst4   = 1'b1;
        update = 1'b0;
        empty  = 4'b0000;
        delta4 = '0;
        set_delta(2, 1, 0, 3);
        tick();
        tick();
        chk_dut("rst", 0, 0, 0, 0);
        chk_wc("rst", 0, 0, 0, 0);
        chk_w4("rst", 0, 0, 0);

        // Release: first edge loads, outputs still idle
        reset = 1'b0;
        tick();
        chk_dut("load", 0, 0, 0, 0);
        for (int fr = 0; fr < 2; fr++) begin
            for (int k = 0; k < 6; k++) begin
                tick();
                chk_dut("f1", f1[k], (k == 0) ? 1 : 0, 1, f1[k]);
                chk_wc("f1", f1[k], (k == 0) ? 1 : 0, 1, f1[k]);
            end
        end

        // Queue 1 empty
        empty = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_dut("e1", f1[k], (k == 0) ? 1 : 0, (f1[k] == 1) ? 0 : 1, f1[k]);
            chk_wc("e1", f1[k], (k == 0) ? 1 : 0, 1, (f1[k] == 1) ? 2 : f1[k]);
        end

        // Queues 1 and 3 empty: slot 3 lends to queue 0 (wrap)
        empty = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_dut("e13", f1[k], (k == 0) ? 1 : 0, (f1[k] == 0) ? 1 : 0, f1[k]);
            chk_wc("e13", f1[k], (k == 0) ? 1 : 0, 1, (f1[k] == 1) ? 2 : ((f1[k] == 3) ? 0 : f1[k]));
        end

        // All empty
        empty = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_dut("eall", f1[k], (k == 0) ? 1 : 0, 0, f1[k]);
            chk_wc("eall", f1[k], (k == 0) ? 1 : 0, 0, f1[k]);
        end
        empty = 4'b0000;

        // Mid-frame reload request: current frame finishes unchanged
        tick();
        chk_dut("mid0", 0, 1, 1, 0);
        tick();
        chk_dut("mid1", 0, 0, 1, 0);
        set_delta(1, 1, 1, 1);
        update = 1'b1;
        tick();
        chk_dut("mid2", 1, 0, 1, 1);
        update = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_dut("mid3", 3, 0, 1, 3);
        end
        for (int fr = 0; fr < 2; fr++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk_dut("f2", k, (k == 0) ? 1 : 0, 1, k);
            end
        end

        // delta change without update has no effect
        set_delta(2, 2, 2, 2);
        for (int fr = 0; fr < 2; fr++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk_dut("noupd", k, (k == 0) ? 1 : 0, 1, k);
            end
        end

        // Reset asserted while slot 3 is showing
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_dut("pre", k, (k == 0) ? 1 : 0, 1, k);
        end
        set_delta(2, 1, 0, 3);
        reset = 1'b1;
        #1;
        chk_dut("async", 0, 0, 0, 0);
        chk_wc("async", 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        chk_dut("reload", 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_dut("rf", f1[k], (k == 0) ? 1 : 0, 1, f1[k]);
        end

        // All-zero delta: idle indefinitely
        set_delta(0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk_dut("idle", 0, 0, 0, 0);
        end
        set_delta(0, 0, 5, 0);
        update = 1'b1;
        tick();
        chk_dut("idle_upd", 0, 0, 0, 0);
        update = 1'b0;
        tick();
        chk_dut("idle_load", 0, 0, 0, 0);
        for (int fr = 0; fr < 3; fr++) begin
            for (int k = 0; k < 5; k++) begin
                tick();
                chk_dut("s2", 2, (k == 0) ? 1 : 0, 1, 2);
            end
        end

        // 4-bit build: slot 0 of length 15 then slot 1 of length 1
        delta4[0] = 4'd15;
        delta4[1] = 4'd1;
        rst4 = 1'b0;
        tick();
        chk_w4("w4load", 0, 0, 0);
        for (int fr = 0; fr < 2; fr++) begin
            for (int k = 0; k < 16; k++) begin
                tick();
                chk_w4("w4", (k < 15) ? 0 : 1, (k == 0) ? 1 : 0, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
